// File: rtl/lvds_frame_sched.sv
// Transmit scheduler for the serial LVDS uplink: arbitrates digital-change and
// heartbeat requests, frames each grant as a 16-bit word and shifts it out MSB first.
module lvds_frame_sched #(
  parameter int BIT_DIV          = 4,
  parameter int HEARTBEAT_PERIOD = 16000,
  parameter int GAP_BITS         = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] D_IN,
  output logic       TX_DATA,
  output logic       TX_FRAME,
  output logic       BUSY,
  output logic [7:0] DROP_CNT,
  output logic [1:0] FSM_STATE
);

  localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int HB_W    = $clog2(HEARTBEAT_PERIOD);
  localparam int GAP_CYC = GAP_BITS * BIT_DIV;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state;
  logic [7:0]       din_meta;
  logic [7:0]       din_s;
  logic [7:0]       din_last;
  logic [7:0]       dig_payload;
  logic             pend_dig;
  logic             pend_hb;
  logic             last_grant_hb;
  logic [5:0]       seq;
  logic [7:0]       drop_cnt;
  logic [HB_W-1:0]  hb_cnt;
  logic [15:0]      shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic        din_change;
  logic        hb_tick;
  logic        grant_any;
  logic        grant_dig;
  logic        grant_hb;
  logic [15:0] frame_word;

  assign din_change = (din_s != din_last);
  assign hb_tick    = (hb_cnt == HB_W'(HEARTBEAT_PERIOD - 1));
  assign grant_any  = (state == ST_IDLE) && (pend_dig || pend_hb);
  // On a tie the type that did not win last time goes next.
  assign grant_dig  = grant_any && pend_dig && (!pend_hb || last_grant_hb);
  assign grant_hb   = grant_any && !grant_dig;
  assign frame_word = grant_dig ? {2'b01, seq, dig_payload} : {2'b10, seq, din_s};

  // TX_FRAME is a valid-only strobe: the lane driver has no ready, so every
  // cycle with TX_FRAME high carries a frame bit on TX_DATA and is consumed.
  assign TX_FRAME  = (state == ST_SHIFT);
  assign TX_DATA   = TX_FRAME & shreg[15];
  assign BUSY      = (state != ST_IDLE);
  assign DROP_CNT  = drop_cnt;
  assign FSM_STATE = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      din_meta <= 8'h00;
      din_s    <= 8'h00;
    end else begin
      din_meta <= D_IN;
      din_s    <= din_meta;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hb_cnt      <= '0;
      din_last    <= 8'h00;
      dig_payload <= 8'h00;
      pend_dig    <= 1'b0;
      pend_hb     <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      hb_cnt <= hb_tick ? '0 : hb_cnt + HB_W'(1);
      if (din_change) begin
        din_last    <= din_s;
        dig_payload <= din_s;
      end
      // A change landing on the grant edge refills the flag without a drop.
      if (din_change && pend_dig && !grant_dig && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      if (din_change)
        pend_dig <= 1'b1;
      else if (grant_dig)
        pend_dig <= 1'b0;
      if (hb_tick)
        pend_hb <= 1'b1;
      else if (grant_hb)
        pend_hb <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      shreg         <= 16'h0000;
      seq           <= 6'd0;
      last_grant_hb <= 1'b1;
      div_cnt       <= '0;
      bit_cnt       <= 4'd0;
      gap_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            shreg         <= frame_word;
            seq           <= seq + 6'd1;
            last_grant_hb <= grant_hb;
            div_cnt       <= '0;
            bit_cnt       <= 4'd0;
            state         <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_W'(BIT_DIV - 1)) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd15) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= {shreg[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1))
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_frame_sched.sv
// Randomised bench for lvds_frame_sched: a slot-based reference model predicts
// each frame word and its start cycle; a monitor rebuilds frames off the lane.
module tb_lvds_frame_sched;

  localparam int B    = 2;
  localparam int P    = 200;
  localparam int G    = 2;
  localparam int FRM  = 16 * B;
  localparam int SLOT = 16 * B + G * B + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       tx_data;
  logic       tx_frame;
  logic       busy;
  logic [7:0] drop_cnt;
  logic [1:0] fsm_state;

  lvds_frame_sched #(
    .BIT_DIV(B),
    .HEARTBEAT_PERIOD(P),
    .GAP_BITS(G)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .D_IN(d_in),
    .TX_DATA(tx_data),
    .TX_FRAME(tx_frame),
    .BUSY(busy),
    .DROP_CNT(drop_cnt),
    .FSM_STATE(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  // The line is treated as a sequence of slots: a grant at edge g occupies the
  // lane for 16*B cycles, then the gap, and the next grant may happen at g+SLOT.
  logic [7:0] m_d1, m_d2, m_last, m_payload;
  bit         m_pd, m_ph, m_last_hb;
  logic [5:0] m_seq;
  int         m_drop, m_g, m_next_free;

  task automatic model_reset();
    m_d1 = 8'h00; m_d2 = 8'h00; m_last = 8'h00; m_payload = 8'h00;
    m_pd = 0; m_ph = 0; m_last_hb = 1;
    m_seq = 6'd0; m_drop = 0; m_g = -1000; m_next_free = 0;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // Advance the model across edge n, where din_s seen at that edge is D_IN(n-2).
  task automatic model_step(input int n, input logic [7:0] d_now);
    logic [7:0] ds;
    bit g_dig;
    ds = m_d2;
    g_dig = 0;
    if (n >= m_next_free && (m_pd || m_ph)) begin
      g_dig = m_pd && (!m_ph || m_last_hb);
      if (g_dig) exp_q.push_back({2'b01, m_seq, m_payload});
      else       exp_q.push_back({2'b10, m_seq, ds});
      exp_cyc_q.push_back(n);
      m_seq = m_seq + 6'd1;
      m_last_hb = !g_dig;
      if (g_dig) m_pd = 0; else m_ph = 0;
      m_g = n;
      m_next_free = n + SLOT;
    end
    if (ds != m_last) begin
      if (m_pd && m_drop < 255) m_drop++;
      m_pd = 1;
      m_payload = ds;
      m_last = ds;
    end
    if (n % P == 0) m_ph = 1;
    m_d2 = m_d1;
    m_d1 = d_now;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic [7:0] d);
    d_in = d;
    model_step(cyc + 1, d);
    @(negedge clk);
    check("busy", busy, (cyc >= m_g && cyc < m_g + SLOT - 1) ? 1 : 0);
    check("tx_frame", tx_frame, (cyc >= m_g && cyc < m_g + FRM) ? 1 : 0);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_tx_frame", tx_frame, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  bit          cap_active = 0;
  bit          cap_has_exp = 0;
  int          cap_len = 0;
  logic [15:0] cap_word = 16'h0;
  logic [15:0] cap_exp = 16'h0;

  always @(negedge clk) begin
    if (rst) begin
      cap_active = 0;
    end else if (!tx_frame) begin
      check("idle_tx_data", tx_data, 0);
      if (cap_active) begin
        check("frame_len", cap_len, FRM);
        if (cap_has_exp) check("frame_word", cap_word, cap_exp);
        cap_active = 0;
      end
    end else begin
      if (!cap_active) begin
        cap_active = 1;
        cap_len = 0;
        cap_word = 16'h0;
        check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        cap_has_exp = (exp_q.size() > 0);
        if (cap_has_exp) begin
          cap_exp = exp_q.pop_front();
          check("frame_start_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      if (cap_len % B == 0) cap_word = {cap_word[14:0], tx_data};
      else check("bit_hold", tx_data, cap_word[0]);
      cap_len++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g0;
    int guard;
    logic [7:0] v;
    int h;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_frame", tx_frame, 0);
    check("reset_busy", busy, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_fsm_idle", fsm_state, 0);
    #2 rst = 1'b0;

    // Single digital change from idle, then the first heartbeat.
    repeat (260) tick(8'h01);

    // Constant input: heartbeat train long enough to wrap seq.
    repeat (65 * P + 40) tick(8'h00);

    // Reset in the middle of a frame; next frame restarts at seq 0.
    g0 = m_g;
    guard = 0;
    tick(8'h77);
    while (!(m_g != g0 && cyc == m_g + 10) && guard < 400) begin
      tick(8'h77);
      guard++;
    end
    check("mid_frame_reached", (m_g != g0 && cyc == m_g + 10) ? 1 : 0, 1);
    check("mid_frame_busy", busy, 1);
    pulse_reset();
    repeat (60) tick(8'h77);

    // Three changes while one frame is on the line.
    repeat (6) tick(8'h55);
    repeat (4) tick(8'h11);
    repeat (4) tick(8'h22);
    repeat (4) tick(8'h33);
    repeat (60) tick(8'h33);
    check("drop_after_three", drop_cnt, 2);

    // Rapid toggling saturates the drop counter.
    for (int i = 0; i < 300; i++) tick(i[0] ? 8'hAA : 8'h55);
    repeat (3) tick(8'h55);
    check("drop_saturated", drop_cnt, 255);

    // Tie on the first heartbeat edge: digital wins, then grants alternate.
    pulse_reset();
    while (cyc < P - 3) tick(8'h00);
    repeat (10) tick(8'h3C);
    repeat (200) tick(8'hC3);

    // Random traffic.
    pulse_reset();
    for (int r = 0; r < 150; r++) begin
      v = 8'($urandom_range(0, 255));
      h = $urandom_range(1, 60);
      repeat (h) tick(v);
    end

    guard = 0;
    while ((exp_q.size() != 0 || cap_active) && guard < 1000) begin
      tick(v);
      guard++;
    end
    repeat (2) tick(v);
    check("drain_complete", exp_q.size() + (cap_active ? 1 : 0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
